// File: rtl/prog_mem_ctrl_if.sv
// rtl/prog_mem_ctrl_if.sv - fetch and loader port bundle for prog_mem_ctrl (load_cksum only with PMEM_CKSUM_EN)
interface prog_mem_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_hold;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
`ifdef PMEM_CKSUM_EN
  logic [DATA_W-1:0] load_cksum;

  modport master (
    output fetch_addr, load_start, load_valid, load_data,
    input  fetch_data, cpu_hold, load_ready, load_done, load_count, load_cksum
  );
  modport slave (
    input  fetch_addr, load_start, load_valid, load_data,
    output fetch_data, cpu_hold, load_ready, load_done, load_count, load_cksum
  );
`else
  modport master (
    output fetch_addr, load_start, load_valid, load_data,
    input  fetch_data, cpu_hold, load_ready, load_done, load_count
  );
  modport slave (
    input  fetch_addr, load_start, load_valid, load_data,
    output fetch_data, cpu_hold, load_ready, load_done, load_count
  );
`endif
endinterface

// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - register-based program memory with byte-serial loader and CPU hold (optional PMEM_CKSUM_EN)
module prog_mem_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  prog_mem_ctrl_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_hold;
  logic                w_load_ready;
  logic                w_load_done;
  logic                w_xfer;
  logic                w_ptr_last;

  assign w_xfer     = w_load_ready & bus.load_valid;
  assign w_ptr_last = (r_ptr == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next_state;
  end

  // Next state and handshake outputs; a full memory wins over a same-cycle terminate
  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_load_done  = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (bus.load_start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_load_ready = 1'b1;
        if ((bus.load_valid && w_ptr_last) || bus.load_start) w_next_state = S_FLUSH;
      end
      S_FLUSH: begin
        w_load_done  = 1'b1;
        w_next_state = S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  // Memory array: cleared on reset, written only by accepted loader bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_xfer) begin
      r_mem[r_ptr] <= bus.load_data;
    end
  end

  // Write pointer, byte count and CPU hold; hold tracks entry to LOAD and exit from FLUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_hold  <= 1'b0;
    end else begin
      if (r_state == S_RUN && bus.load_start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_hold  <= 1'b1;
      end else if (r_state == S_FLUSH) begin
        r_hold  <= 1'b0;
      end
      if (w_xfer) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef PMEM_CKSUM_EN
  logic [DATA_W-1:0] r_cksum;

  // Running byte sum of the current load, cleared when a load begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_cksum <= '0;
    else if (r_state == S_RUN && bus.load_start) r_cksum <= '0;
    else if (w_xfer)                             r_cksum <= r_cksum + bus.load_data;
  end

  assign bus.load_cksum = r_cksum;
`endif

  assign bus.fetch_data = r_hold ? '0 : r_mem[bus.fetch_addr];
  assign bus.cpu_hold   = r_hold;
  assign bus.load_ready = w_load_ready;
  assign bus.load_done  = w_load_done;
  assign bus.load_count = r_count;
endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - randomized self-checking bench for prog_mem_ctrl against an array model
module tb_prog_mem_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  prog_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model_mem [DEPTH];
  int          model_count;
  logic [7:0]  model_cksum;
  logic [7:0]  stim [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.fetch_addr = AW'(a);
      #1;
      check($sformatf("%s_addr%0d", tag, a), 32'(bus.fetch_data), 32'(model_mem[a]));
    end
  endtask

  // Loads stim[]; term_last raises load_start together with the last byte, throttle randomizes load_valid
  task automatic do_load(input string tag, input bit term_last, input bit throttle);
    int n;
    int idx;
    int guard;
    bit v;
    n     = stim.size();
    idx   = 0;
    guard = 0;
    model_count = 0;
    model_cksum = 8'h00;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    while (idx < n && guard < 200) begin
      v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.load_valid = v;
      bus.load_data  = stim[idx];
      bus.load_start = term_last && v && (idx == n - 1);
      @(negedge clk);
      check({tag, "_hold"},  32'(bus.cpu_hold), 32'd1);
      check({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
      check({tag, "_fzero"}, 32'(bus.fetch_data), 32'd0);
      tick();
      if (v) begin
        model_mem[idx] = stim[idx];
        model_count++;
        model_cksum += stim[idx];
        idx++;
      end
      guard++;
    end
    if (guard >= 200) check({tag, "_timeout"}, 32'd0, 32'd1);
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    if (n < DEPTH && (!term_last || n == 0)) begin
      bus.load_start = 1'b1;
      @(negedge clk);
      check({tag, "_term_ready"}, 32'(bus.load_ready), 32'd1);
      tick();
      bus.load_start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done"},        32'(bus.load_done), 32'd1);
    check({tag, "_flush_ready"}, 32'(bus.load_ready), 32'd0);
    check({tag, "_flush_hold"},  32'(bus.cpu_hold), 32'd1);
    check({tag, "_count"},       32'(bus.load_count), 32'(model_count));
`ifdef PMEM_CKSUM_EN
    check({tag, "_cksum"},       32'(bus.load_cksum), 32'(model_cksum));
`endif
    tick();
    @(negedge clk);
    check({tag, "_done_low"},  32'(bus.load_done), 32'd0);
    check({tag, "_hold_low"},  32'(bus.cpu_hold), 32'd0);
    check({tag, "_count_run"}, 32'(bus.load_count), 32'(model_count));
`ifdef PMEM_CKSUM_EN
    check({tag, "_cksum_run"}, 32'(bus.load_cksum), 32'(model_cksum));
`endif
    sweep(tag);
  endtask

  initial begin
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_hold",  32'(bus.cpu_hold), 32'd0);
    check("rst_ready", 32'(bus.load_ready), 32'd0);
    check("rst_done",  32'(bus.load_done), 32'd0);
    check("rst_count", 32'(bus.load_count), 32'd0);
`ifdef PMEM_CKSUM_EN
    check("rst_cksum", 32'(bus.load_cksum), 32'd0);
`endif
    sweep("rst");

    // Full back-to-back load
    tick();
    stim = '{8'h60, 8'h90, 8'h3D, 8'h01, 8'hE3, 8'h01, 8'hE1, 8'h90,
             8'h9F, 8'hF7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load("full", 1'b0, 1'b0);
    bus.fetch_addr = 4'd2; #1 check("full_a2", 32'(bus.fetch_data), 32'h3D);
    bus.fetch_addr = 4'd9; #1 check("full_a9", 32'(bus.fetch_data), 32'hF7);

    // Early terminate over a memory of 0xAA
    tick();
    stim.delete();
    for (int i = 0; i < DEPTH; i++) stim.push_back(8'hAA);
    do_load("aa", 1'b0, 1'b0);
    tick();
    stim = '{8'h11, 8'h22, 8'h33};
    do_load("early", 1'b1, 1'b0);

    // Throttled load
    tick();
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
    do_load("thr", 1'b0, 1'b1);

    // Zero-length load
    tick();
    stim.delete();
    do_load("zero", 1'b1, 1'b0);

    // Random loads
    for (int k = 0; k < 8; k++) begin
      tick();
      stim.delete();
      for (int i = 0; i < int'($urandom_range(0, DEPTH)); i++) stim.push_back(8'($urandom));
      do_load($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef PMEM_CKSUM_EN
    tick();
    stim = '{8'hF0, 8'h20, 8'h05};
    do_load("ck", 1'b1, 1'b0);
    check("ck_value", 32'(bus.load_cksum), 32'h15);
`endif

    // Reset in the middle of a load
    tick();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'($urandom);
      tick();
    end
    bus.load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_hold",  32'(bus.cpu_hold), 32'd0);
    check("mid_ready", 32'(bus.load_ready), 32'd0);
    check("mid_count", 32'(bus.load_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    sweep("mid");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.load_valid = 1'(i % 2 == 0);
      bus.load_data  = 8'($urandom);
      @(negedge clk);
      check("run_ready", 32'(bus.load_ready), 32'd0);
      check("run_hold",  32'(bus.cpu_hold), 32'd0);
      tick();
    end
    bus.load_valid = 1'b0;
    sweep("run_ign");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
